// File: rtl/awg_pkg.sv
// Shared AWG definitions: status packet layout and waveform encoding.
package awg_pkg;

  localparam logic [7:0] STATUS_HEADER = 8'hA5;
  localparam int unsigned PKT_LEN = 9;

  // Byte positions within the status packet
  localparam logic [3:0] IDX_HEADER   = 4'd0;
  localparam logic [3:0] IDX_WAVE     = 4'd1;
  localparam logic [3:0] IDX_FREQ_HI  = 4'd2;
  localparam logic [3:0] IDX_FREQ_LO  = 4'd3;
  localparam logic [3:0] IDX_AMP_HI   = 4'd4;
  localparam logic [3:0] IDX_AMP_LO   = 4'd5;
  localparam logic [3:0] IDX_OFF_HI   = 4'd6;
  localparam logic [3:0] IDX_OFF_LO   = 4'd7;
  localparam logic [3:0] IDX_CHECKSUM = 4'd8;

  // Same encoding the command decoder uses
  typedef enum logic [1:0] {
    WaveSine     = 2'd0,
    WaveSquare   = 2'd1,
    WaveTriangle = 2'd2,
    WaveSawtooth = 2'd3
  } waveform_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StSend = 1'b1
  } report_state_e;

  typedef struct packed {
    waveform_e   wave;
    logic [15:0] freq;
    logic [9:0]  amp;
    logic [9:0]  off;
  } status_snap_t;

  // XOR of payload bytes 1..7; the header is deliberately excluded
  function automatic logic [7:0] status_checksum(input status_snap_t s);
    return {6'b0, s.wave} ^ s.freq[15:8] ^ s.freq[7:0] ^ {6'b0, s.amp[9:8]} ^ s.amp[7:0] ^
           {6'b0, s.off[9:8]} ^ s.off[7:0];
  endfunction

  function automatic logic [7:0] status_byte(input logic [3:0] idx, input logic [7:0] header,
                                             input status_snap_t s);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      IDX_HEADER:   b = header;
      IDX_WAVE:     b = {6'b0, s.wave};
      IDX_FREQ_HI:  b = s.freq[15:8];
      IDX_FREQ_LO:  b = s.freq[7:0];
      IDX_AMP_HI:   b = {6'b0, s.amp[9:8]};
      IDX_AMP_LO:   b = s.amp[7:0];
      IDX_OFF_HI:   b = {6'b0, s.off[9:8]};
      IDX_OFF_LO:   b = s.off[7:0];
      IDX_CHECKSUM: b = status_checksum(s);
      default:      b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/status_period_timer.sv
// Free-running period counter; pulses period_tick on the wrap cycle.
module status_period_timer #(
  parameter int unsigned REPORT_PERIOD = 0,
  parameter int unsigned PERIOD_W      = 32
) (
  input  logic clk,
  input  logic rst,
  output logic period_tick
);

  localparam logic [PERIOD_W-1:0] LastCnt =
      (REPORT_PERIOD == 0) ? '0 : PERIOD_W'(REPORT_PERIOD - 1);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;

  // Next count and tick; a zero period parks the counter at 0 with no ticks
  always_comb begin
    cnt_d       = cnt_q;
    period_tick = 1'b0;
    if (REPORT_PERIOD != 0) begin
      if (cnt_q == LastCnt) begin
        period_tick = 1'b1;
        cnt_d       = '0;
      end else begin
        cnt_d = cnt_q + PERIOD_W'(1);
      end
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/status_reporter.sv
// Snapshots generator settings and streams them as a 9-byte status packet to UART TX.
module status_reporter
  import awg_pkg::*;
#(
  parameter logic [7:0]  HEADER        = STATUS_HEADER,
  parameter int unsigned REPORT_PERIOD = 0,
  parameter int unsigned PERIOD_W      = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [1:0]  waveform_type,
  input  logic [15:0] frequency,
  input  logic [9:0]  amplitude,
  input  logic [9:0]  dc_offset,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        packet_done
);

  logic          period_tick;
  report_state_e state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  status_snap_t  snap_q, snap_d;
  logic          pending_q, pending_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          new_req;

  status_period_timer #(
    .REPORT_PERIOD (REPORT_PERIOD),
    .PERIOD_W      (PERIOD_W)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .period_tick (period_tick)
  );

  assign new_req = req | period_tick;

  // Packet sequencing: snapshot on start, advance one byte per accepted transfer
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    pending_d = pending_q;
    data_d    = data_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (new_req || pending_q) begin
          snap_d.wave = waveform_e'(waveform_type);
          snap_d.freq = frequency;
          snap_d.amp  = amplitude;
          snap_d.off  = dc_offset;
          pending_d   = 1'b0;
          idx_d       = IDX_HEADER;
          data_d      = HEADER;
          valid_d     = 1'b1;
          busy_d      = 1'b1;
          state_d     = StSend;
        end
      end
      StSend: begin
        // Requests while sending coalesce into a single follow-up packet
        if (new_req) pending_d = 1'b1;
        if (valid_q && tx_ready) begin
          if (idx_q == IDX_CHECKSUM) begin
            idx_d   = IDX_HEADER;
            data_d  = 8'h00;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            idx_d  = idx_q + 4'd1;
            data_d = status_byte(idx_q + 4'd1, HEADER, snap_q);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      snap_q    <= '0;
      pending_q <= 1'b0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      pending_q <= pending_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx_data     = data_q;
  assign tx_valid    = valid_q;
  assign busy        = busy_q;
  assign packet_done = done_q;

endmodule

// File: tb/tb_status_reporter.sv
// Directed + randomized bench for status_reporter against a packet-level model.
module tb_status_reporter;

  logic        clk = 1'b0;
  logic        rst, req, tx_ready;
  logic [1:0]  wt;
  logic [15:0] fr;
  logic [9:0]  amp, off;
  logic [7:0]  tx_data;
  logic        tx_valid, busy, packet_done;

  logic        rst_p, req_p, tx_ready_p;
  logic [7:0]  tx_data_p;
  logic        tx_valid_p, busy_p, packet_done_p;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] got_p[$];
  int         xfer_cyc[$];
  int         done_cyc[$];
  int         rises[$];

  always #5 clk = ~clk;

  status_reporter #(
    .HEADER        (8'hA5),
    .REPORT_PERIOD (0),
    .PERIOD_W      (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .waveform_type (wt),
    .frequency     (fr),
    .amplitude     (amp),
    .dc_offset     (off),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .busy          (busy),
    .packet_done   (packet_done)
  );

  status_reporter #(
    .HEADER        (8'hA5),
    .REPORT_PERIOD (20),
    .PERIOD_W      (32)
  ) dut_p (
    .clk           (clk),
    .rst           (rst_p),
    .req           (req_p),
    .waveform_type (wt),
    .frequency     (fr),
    .amplitude     (amp),
    .dc_offset     (off),
    .tx_data       (tx_data_p),
    .tx_valid      (tx_valid_p),
    .tx_ready      (tx_ready_p),
    .busy          (busy_p),
    .packet_done   (packet_done_p)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packet model: fields laid out as bytes, checksum is XOR of bytes 1..7
  task automatic model_push(input logic [1:0] w, input logic [15:0] f, input logic [9:0] a,
                            input logic [9:0] o);
    logic [7:0] b[9];
    b[0] = 8'hA5;
    b[1] = {6'b0, w};
    b[2] = f[15:8];
    b[3] = f[7:0];
    b[4] = {6'b0, a[9:8]};
    b[5] = a[7:0];
    b[6] = {6'b0, o[9:8]};
    b[7] = o[7:0];
    b[8] = 8'h00;
    for (int i = 1; i < 8; i++) b[8] = b[8] ^ b[i];
    for (int i = 0; i < 9; i++) exp_q.push_back(b[i]);
  endtask

  task automatic randomize_inputs();
    wt  = 2'($urandom);
    fr  = 16'($urandom);
    amp = 10'($urandom);
    off = 10'($urandom);
  endtask

  task automatic clear_logs();
    exp_q.delete();
    got_q.delete();
    xfer_cyc.delete();
    done_cyc.delete();
  endtask

  // One clock: log transfers for the edge about to happen, then check hold-stability after it
  task automatic tick();
    logic       hold_v;
    logic [7:0] hold_d;
    if (tx_valid && tx_ready) begin
      got_q.push_back(tx_data);
      xfer_cyc.push_back(cyc);
    end
    if (packet_done) done_cyc.push_back(cyc);
    hold_v = tx_valid && !tx_ready;
    hold_d = tx_data;
    @(negedge clk);
    cyc++;
    if (hold_v && !rst)
      check("hold_stable", {23'b0, tx_valid, tx_data}, {24'h1, hold_d});
  endtask

  task automatic wait_done(input int n, input int max_cycles);
    int k;
    k = 0;
    while (done_cyc.size() < n && k < max_cycles) begin
      tx_ready = 1'b1;
      tick();
      k++;
    end
    check("done_count", 32'(done_cyc.size()), 32'(n));
  endtask

  task automatic compare_pkts(input string tag);
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; tx_ready = 1'b0;
    wt = 2'd0; fr = 16'h0; amp = 10'h0; off = 10'h0;
    rst_p = 1'b1; req_p = 1'b0; tx_ready_p = 1'b1;
    @(negedge clk);
    repeat (3) tick();

    // Reset state
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(packet_done), 32'h0);
    rst = 1'b0;
    tick();

    // Single request, back-to-back transfers
    clear_logs();
    wt = 2'd2; fr = 16'h1234; amp = 10'h3FF; off = 10'h200;
    model_push(wt, fr, amp, off);
    req = 1'b1; tx_ready = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("b2b_valid%0d", i), 32'(tx_valid), 32'h1);
      check($sformatf("b2b_busy%0d", i), 32'(busy), 32'h1);
      check($sformatf("b2b_data%0d", i), 32'(tx_data), 32'(exp_q[i]));
      check($sformatf("b2b_nodone%0d", i), 32'(packet_done), 32'h0);
      tick();
    end
    check("b2b_done", 32'(packet_done), 32'h1);
    check("b2b_end_valid", 32'(tx_valid), 32'h0);
    check("b2b_end_busy", 32'(busy), 32'h0);
    tick();
    check("b2b_done_pulse", 32'(packet_done), 32'h0);

    // Backpressure with random tx_ready; first pass uses the reference values
    for (int it = 0; it < 6; it++) begin
      clear_logs();
      if (it == 0) begin
        wt = 2'd2; fr = 16'h1234; amp = 10'h3FF; off = 10'h200;
      end else begin
        randomize_inputs();
      end
      model_push(wt, fr, amp, off);
      req = 1'b1;
      tx_ready = 1'($urandom);
      tick();
      req = 1'b0;
      for (int k = 0; k < 300 && done_cyc.size() == 0; k++) begin
        tx_ready = 1'($urandom);
        tick();
      end
      check("bp_done_count", 32'(done_cyc.size()), 32'h1);
      compare_pkts($sformatf("bp%0d", it));
      tx_ready = 1'b1;
      tick();
    end

    // Snapshot isolation: frequency changes right after the request
    clear_logs();
    wt = 2'd2; fr = 16'h1234; amp = 10'h3FF; off = 10'h200;
    model_push(wt, fr, amp, off);
    req = 1'b1;
    tick();
    req = 1'b0;
    fr = 16'hFFFF;
    wait_done(1, 50);
    compare_pkts("snap");
    tick();

    // Three requests mid-packet coalesce into one follow-up packet
    clear_logs();
    randomize_inputs();
    model_push(wt, fr, amp, off);
    req = 1'b1; tick(); req = 1'b0; tick();
    req = 1'b1; tick(); req = 1'b0; tick();
    req = 1'b1; tick(); req = 1'b0; tick();
    req = 1'b1; tick(); req = 1'b0;
    randomize_inputs();
    model_push(wt, fr, amp, off);
    for (int k = 0; k < 40; k++) tick();
    check("coalesce_done_count", 32'(done_cyc.size()), 32'h2);
    compare_pkts("coalesce");
    if (done_cyc.size() >= 1 && xfer_cyc.size() >= 10) begin
      check("coalesce_done_after_last", 32'(done_cyc[0]), 32'(xfer_cyc[8] + 1));
      check("coalesce_one_idle", 32'(xfer_cyc[9]), 32'(done_cyc[0] + 1));
    end else begin
      check("coalesce_timing_logged", 32'(xfer_cyc.size()), 32'd18);
    end

    // Reset while byte 4 is presented
    clear_logs();
    randomize_inputs();
    model_push(wt, fr, amp, off);
    req = 1'b1; tick(); req = 1'b0;
    repeat (4) tick();
    check("mid_byte4", 32'(tx_data), 32'(exp_q[4]));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_data", 32'(tx_data), 32'h0);
    check("mid_rst_valid", 32'(tx_valid), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_done", 32'(packet_done), 32'h0);
    for (int k = 0; k < 20; k++) tick();
    check("mid_rst_no_completion", 32'(done_cyc.size()), 32'h0);
    clear_logs();
    randomize_inputs();
    model_push(wt, fr, amp, off);
    req = 1'b1; tick(); req = 1'b0;
    wait_done(1, 50);
    compare_pkts("post_rst");

    // Periodic instance: packets every 20 cycles with no request
    clear_logs();
    randomize_inputs();
    for (int n = 0; n < 5; n++) model_push(wt, fr, amp, off);
    begin
      logic prev_v;
      int   dones;
      prev_v = 1'b0;
      dones  = 0;
      rst_p  = 1'b0;
      for (int j = 1; j <= 110; j++) begin
        tick();
        if (tx_valid_p && !prev_v) rises.push_back(j);
        if (tx_valid_p) got_p.push_back(tx_data_p);
        if (packet_done_p) dones++;
        prev_v = tx_valid_p;
      end
      check("per_packets", 32'(rises.size()), 32'd5);
      for (int n = 0; n < rises.size(); n++)
        check($sformatf("per_start%0d", n), 32'(rises[n]), 32'(20 * (n + 1)));
      check("per_done_count", 32'(dones), 32'd5);
      check("per_len", 32'(got_p.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
        if (i < got_p.size()) check($sformatf("per_b%0d", i), 32'(got_p[i]), 32'(exp_q[i]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
